// File: rtl/camera_config_sequencer.sv
// Walks a {reg_addr,reg_value} ROM table and issues one SCCB write per entry, with delay and end-marker entries.
// Optional build macro CFG_TIMEOUT_EN adds a per-write timeout that aborts the run and raises err.
module camera_config_sequencer #(
  parameter int ROM_AW       = 8,
  parameter int DELAY_CYCLES = 1_000_000
`ifdef CFG_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC  = 65_535
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROM_AW-1:0] wr_count
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_ROMWAIT = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_SEND    = 4'd4;
  localparam logic [3:0] S_WACK    = 4'd5;
  localparam logic [3:0] S_WDONE   = 4'd6;
  localparam logic [3:0] S_DELAY   = 4'd7;
  localparam logic [3:0] S_NEXT    = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [15:0] DELAY_ENT = 16'hFFF0;

  localparam int              DW       = $clog2(DELAY_CYCLES + 1);
  localparam logic [DW-1:0]   DLY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [ROM_AW-1:0] IDX_MAX = '1;

  logic [3:0]        state;
  logic [ROM_AW-1:0] idx;
  logic [DW-1:0]     dcnt;
  logic              in_write;
  logic              to_hit;
  logic              start_ok;

  assign rom_addr = idx;
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign in_write = (state == S_SEND) || (state == S_WACK) || (state == S_WDONE);
  // start only counts from IDLE or DONE; pulses during a run are dropped
  assign start_ok = start && !busy;

`ifdef CFG_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt;

  assign to_hit = in_write && (tcnt == TO_LAST);

  // counter is held at 0 outside a write so it restarts on every SEND entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (in_write) tcnt <= tcnt + 1'b1;
      else          tcnt <= '0;
      if (start_ok)    err <= 1'b0;
      else if (to_hit) err <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      dcnt       <= '0;
      sccb_start <= 1'b0;
      sccb_reg   <= 8'h00;
      sccb_val   <= 8'h00;
      wr_count   <= '0;
    end else begin
      sccb_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state    <= S_FETCH;
            idx      <= '0;
            wr_count <= '0;
          end
        end
        S_FETCH:   state <= S_ROMWAIT;
        S_ROMWAIT: state <= S_DECODE;
        S_DECODE: begin
          if (rom_data == END_MARK) begin
            state <= S_DONE;
          end else if (rom_data == DELAY_ENT) begin
            state <= S_DELAY;
            dcnt  <= DLY_LOAD;
          end else begin
            sccb_reg <= rom_data[15:8];
            sccb_val <= rom_data[7:0];
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (to_hit) begin
            state <= S_DONE;
          end else if (sccb_ready) begin
            sccb_start <= 1'b1;
            state      <= S_WACK;
          end
        end
        S_WACK: begin
          if (to_hit)           state <= S_DONE;
          else if (!sccb_ready) state <= S_WDONE;
        end
        S_WDONE: begin
          if (to_hit) begin
            state <= S_DONE;
          end else if (sccb_ready) begin
            if (wr_count != IDX_MAX) wr_count <= wr_count + 1'b1;
            state <= S_NEXT;
          end
        end
        S_DELAY: begin
          if (dcnt == '0) state <= S_NEXT;
          else            dcnt  <= dcnt - 1'b1;
        end
        S_NEXT: begin
          // a table with no end marker finishes after its last slot
          if (idx == IDX_MAX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Scoreboard bench for camera_config_sequencer: a ROM model and an SCCB engine model drive the DUT,
// expected writes are queued when a table is loaded and compared as sccb_start pulses appear.
module tb_camera_config_sequencer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic          sccb_start;
  logic [7:0]    sccb_reg;
  logic [7:0]    sccb_val;
  logic          eng_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] wr_count;

  camera_config_sequencer #(
    .ROM_AW(AW),
    .DELAY_CYCLES(50)
`ifdef CFG_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sccb_start(sccb_start),
    .sccb_reg(sccb_reg),
    .sccb_val(sccb_val),
    .sccb_ready(eng_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] rom [0:3];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // engine model: ready drops the cycle after sccb_start, stays low 20 cycles
  int   eng_cnt;
  logic eng_stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_ready <= 1'b1;
      eng_cnt   <= 0;
    end else if (sccb_start) begin
      eng_ready <= 1'b0;
      eng_cnt   <= 20;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end else if (!eng_stuck) begin
      eng_ready <= 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  int   n_starts = 0;
  int   last_start_cyc = 0;
  int   last_rise_cyc = 0;
  int   last_gap = 0;
  int   start_cyc = 0;
  logic prev_ready = 1'b1;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && eng_ready && !prev_ready) last_rise_cyc = cyc;
    prev_ready = eng_ready;
    if (sccb_start) begin
      n_starts++;
      last_start_cyc = cyc;
      last_gap = cyc - last_rise_cyc;
      if (exp_q.size() == 0) begin
        chk("extra_start", {sccb_reg, sccb_val}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("sccb_write", {sccb_reg, sccb_val}, e);
      end
    end
  end

  task automatic load_table(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic push_expected();
    for (int i = 0; i < 4; i++) begin
      if (rom[i] == 16'hFFFF) break;
      if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    int base;
    int lat;
    int n;
    load_table(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("reset_outs", {sccb_start, busy, done, err, wr_count, rom_addr, sccb_reg, sccb_val}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // T1: two writes then end marker
    load_table(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    push_expected();
    base = n_starts;
    pulse_start();
    wait_done("t1_done", 400);
    chk("t1_wr_count", wr_count, 2);
    chk("t1_err", err, 0);
    chk("t1_starts", n_starts - base, 2);
    chk("t1_queue_empty", exp_q.size(), 0);

    // T2: delay entry between writes
    load_table(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
    push_expected();
    base = n_starts;
    pulse_start();
    wait_done("t2_done", 600);
    chk("t2_first_latency_ge5", (n_starts > base) && (last_start_cyc - start_cyc >= 5), 1);
    chk("t2_gap_ge50", last_gap >= 50, 1);
    chk("t2_wr_count", wr_count, 2);
    chk("t2_queue_empty", exp_q.size(), 0);

    // T3: end marker at entry 0
    load_table(16'hFFFF, 16'h1280, 16'h1101, 16'h0000);
    base = n_starts;
    pulse_start();
    wait_done("t3_done", 20);
    lat = cyc - start_cyc;
    chk("t3_done_within4", lat <= 4, 1);
    chk("t3_no_start", n_starts - base, 0);
    chk("t3_wr_count", wr_count, 0);

    // T4: reset during the second write's acknowledge wait
    load_table(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    push_expected();
    base = n_starts;
    pulse_start();
    n = 0;
    while (n_starts < base + 2 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_reached_2nd_write", n_starts - base, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_reset_outs", {sccb_start, busy, done, err, wr_count, rom_addr, sccb_reg, sccb_val}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_expected();
    base = n_starts;
    pulse_start();
    wait_done("t4_replay_done", 400);
    chk("t4_replay_wr_count", wr_count, 2);
    chk("t4_replay_starts", n_starts - base, 2);

    // T5: no end marker, full table; extra starts while busy
    load_table(16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04);
    push_expected();
    base = n_starts;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("t5_busy", busy, 1);
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    wait_done("t5_done", 800);
    chk("t5_starts", n_starts - base, 4);
    chk("t5_wr_count_sat", wr_count, 3);
    chk("t5_queue_empty", exp_q.size(), 0);

`ifdef CFG_TIMEOUT_EN
    // T6: engine never returns ready
    load_table(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    exp_q.push_back(16'h1280);
    eng_stuck = 1'b1;
    base = n_starts;
    pulse_start();
    wait_done("t6_done", 400);
    lat = cyc - last_start_cyc;
    chk("t6_err", err, 1);
    chk("t6_latency", (lat >= 90) && (lat <= 110), 1);
    chk("t6_wr_count", wr_count, 0);
    eng_stuck = 1'b0;
    repeat (3) @(negedge clk);
    push_expected();
    pulse_start();
    chk("t6_err_cleared", err, 0);
    wait_done("t6_rerun_done", 400);
    chk("t6_rerun_err", err, 0);
    chk("t6_rerun_wr_count", wr_count, 2);
`else
    chk("err_tied_low", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
